// File: rtl/noc_output_port_allocator.sv
// Per-output-port switch allocator for the mesh router.
// Arbitrates the five input ports (N,S,W,E,Local) for one output with
// round-robin fairness, holds the output from head to tail flit (wormhole),
// and gates every grant on downstream flow control (credits or ack/nack).
// The grant is combinational from this cycle's requests and registered state.

package noc_alloc_pkg;

  typedef enum logic [2:0] {
    kNorthPort = 3'd0,
    kSouthPort = 3'd1,
    kWestPort  = 3'd2,
    kEastPort  = 3'd3,
    kLocalPort = 3'd4
  } noc_port_t;

  typedef enum logic {
    kFlowControlCreditBased = 1'b0,
    kFlowControlAckNack     = 1'b1
  } flow_control_e;

endpackage

module noc_output_port_allocator
  import noc_alloc_pkg::*;
#(
  parameter int unsigned   PortQueueDepth = 4,
  parameter flow_control_e FlowControl    = kFlowControlCreditBased,
  parameter logic [4:0]    PortsEnable    = 5'b11111,
  localparam int unsigned  CreditsWidth   = $clog2(PortQueueDepth + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              req,
  input  logic [4:0]              head,
  input  logic [4:0]              tail,
  input  logic                    credit_in,
  input  logic                    stop_in,
  output logic [4:0]              gnt,
  output logic                    valid_out,
  output logic                    locked,
  output logic [2:0]              owner,
  output logic [CreditsWidth-1:0] credits,
  output logic                    err
);

  localparam int unsigned NumPorts = 5;
  localparam logic [CreditsWidth-1:0] MaxCredits = CreditsWidth'(PortQueueDepth);

  typedef enum logic {
    kIdle   = 1'b0,
    kLocked = 1'b1
  } state_e;

  state_e                  state_q;
  noc_port_t               rr_ptr_q;
  noc_port_t               owner_q;
  logic [CreditsWidth-1:0] credits_q;
  logic                    err_q;

  logic [4:0] mreq;
  logic [4:0] cand;
  logic       can_send;
  logic       win_found;
  noc_port_t  win_idx;
  logic [4:0] gnt_c;

  // Port index arithmetic modulo five: Local (4) wraps back to North (0).
  function automatic noc_port_t port_add(input noc_port_t base, input int unsigned off);
    logic [3:0] sum;
    sum = {1'b0, base} + 4'(off);
    if (sum >= 4'(NumPorts)) sum = sum - 4'(NumPorts);
    return noc_port_t'(sum[2:0]);
  endfunction

  assign mreq     = req & PortsEnable;
  assign cand     = mreq & head;
  assign can_send = (FlowControl == kFlowControlCreditBased) ? (credits_q != '0) : !stop_in;

  // Round-robin pick of the first head candidate at or after rr_ptr, then the grant.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    win_found = 1'b0;
    win_idx   = kNorthPort;
    gnt_c     = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (!win_found && cand[port_add(rr_ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = port_add(rr_ptr_q, i);
      end
    end
    if (rst) begin
      unique case (state_q)
        kIdle:   if (can_send && win_found) gnt_c[win_idx] = 1'b1;
        kLocked: gnt_c[owner_q] = mreq[owner_q] && can_send;
        default: gnt_c = '0;
      endcase
    end
  end

  assign gnt       = gnt_c;
  assign valid_out = |gnt_c;
  assign locked    = (state_q == kLocked);
  assign owner     = owner_q;
  assign credits   = credits_q;
  assign err       = err_q;

  // Allocation FSM: IDLE grants a new head flit, LOCKED serves only the owner until its tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      state_q  <= kIdle;
      rr_ptr_q <= kNorthPort;
      owner_q  <= kNorthPort;
    end else begin
      unique case (state_q)
        kIdle: begin
          if (valid_out) begin
            rr_ptr_q <= port_add(win_idx, 1);
            owner_q  <= win_idx;
            if (!tail[win_idx]) state_q <= kLocked;
          end
        end
        kLocked: begin
          if (valid_out && tail[owner_q]) state_q <= kIdle;
        end
        default: state_q <= kIdle;
      endcase
    end
  end

  // Downstream credit counter: minus one per transfer, plus one per returned credit, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q <= MaxCredits;
      err_q     <= 1'b0;
    end else if (FlowControl == kFlowControlCreditBased) begin
      unique case ({valid_out, credit_in})
        2'b10: credits_q <= credits_q - CreditsWidth'(1);
        2'b01: begin
          if (credits_q == MaxCredits) err_q <= 1'b1;
          else credits_q <= credits_q + CreditsWidth'(1);
        end
        default: credits_q <= credits_q;
      endcase
    end else begin
      credits_q <= MaxCredits;
    end
  end

endmodule

// File: tb/tb_noc_output_port_allocator.sv
// Directed testbench for noc_output_port_allocator.
// One instance runs in credit mode with all inputs enabled, a second in
// ack/nack mode with inputs N and W disabled. Inputs change 1 ns after the
// rising edge; outputs are compared 1 ns later, well before the next edge.

module tb_noc_output_port_allocator;
  import noc_alloc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Credit-mode instance signals
  logic [4:0] c_req, c_head, c_tail, c_gnt;
  logic       c_credit_in, c_stop_in, c_valid, c_locked, c_err;
  logic [2:0] c_owner, c_credits;

  // Ack/nack-mode instance signals
  logic [4:0] a_req, a_head, a_tail, a_gnt;
  logic       a_credit_in, a_stop_in, a_valid, a_locked, a_err;
  logic [2:0] a_owner, a_credits;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  noc_output_port_allocator #(
    .PortQueueDepth(4),
    .FlowControl   (kFlowControlCreditBased),
    .PortsEnable   (5'b11111)
  ) u_dut_credit (
    .clk      (clk),
    .rst      (rst),
    .req      (c_req),
    .head     (c_head),
    .tail     (c_tail),
    .credit_in(c_credit_in),
    .stop_in  (c_stop_in),
    .gnt      (c_gnt),
    .valid_out(c_valid),
    .locked   (c_locked),
    .owner    (c_owner),
    .credits  (c_credits),
    .err      (c_err)
  );

  noc_output_port_allocator #(
    .PortQueueDepth(4),
    .FlowControl   (kFlowControlAckNack),
    .PortsEnable   (5'b11010)
  ) u_dut_acknack (
    .clk      (clk),
    .rst      (rst),
    .req      (a_req),
    .head     (a_head),
    .tail     (a_tail),
    .credit_in(a_credit_in),
    .stop_in  (a_stop_in),
    .gnt      (a_gnt),
    .valid_out(a_valid),
    .locked   (a_locked),
    .owner    (a_owner),
    .credits  (a_credits),
    .err      (a_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    c_req = '0; c_head = '0; c_tail = '0; c_credit_in = 1'b0; c_stop_in = 1'b0;
    a_req = '0; a_head = '0; a_tail = '0; a_credit_in = 1'b0; a_stop_in = 1'b0;
  endtask

  // Leaves the bench 1 ns after a rising edge with reset just released.
  task automatic apply_reset();
    rst = 1'b0;
    zero_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  // Safety net in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] exp_rr [4];
    logic [4:0] wh_req [5];
    logic [4:0] wh_head [5];
    logic [4:0] wh_tail [5];
    logic [4:0] wh_gnt [5];
    logic       wh_lock [5];

    exp_rr = '{5'b00001, 5'b00010, 5'b10000, 5'b00001};

    wh_req  = '{5'b00100, 5'b01100, 5'b01100, 5'b01100, 5'b01000};
    wh_head = '{5'b00100, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
    wh_tail = '{5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b01000};
    wh_gnt  = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01000};
    wh_lock = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // 1. Reset with every input requesting a head flit.
    zero_inputs();
    rst = 1'b0;
    c_req = 5'b11111; c_head = 5'b11111; c_tail = 5'b11111;
    next_cycle(); #1;
    check("rst_gnt", c_gnt, 5'b00000);
    check("rst_valid", c_valid, 1'b0);
    check("rst_credits", c_credits, 3'd4);
    check("rst_locked", c_locked, 1'b0);
    check("rst_err", c_err, 1'b0);
    check("rst_owner", c_owner, 3'd0);
    next_cycle();
    rst = 1'b1;
    #1;
    check("first_gnt", c_gnt, 5'b00001);
    next_cycle(); #1;
    check("first_credits", c_credits, 3'd3);
    check("second_gnt", c_gnt, 5'b00010);

    // 2. Fair rotation among N, S and Local with single-flit packets.
    apply_reset();
    c_req = 5'b10011; c_head = 5'b10011; c_tail = 5'b10011; c_credit_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_gnt%0d", i), c_gnt, exp_rr[i]);
      next_cycle();
    end
    #1;
    check("rr_credits", c_credits, 3'd4);
    check("rr_err", c_err, 1'b0);

    // 3. West owns the output head..tail while East waits.
    apply_reset();
    c_credit_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_req = wh_req[i]; c_head = wh_head[i]; c_tail = wh_tail[i];
      #1;
      check($sformatf("wh_gnt%0d", i), c_gnt, wh_gnt[i]);
      check($sformatf("wh_lock%0d", i), c_locked, wh_lock[i]);
      if (i == 2) check("wh_owner_west", c_owner, 3'd2);
      next_cycle();
    end
    c_req = '0; c_head = '0; c_tail = '0;
    #1;
    check("wh_owner_east", c_owner, 3'd3);
    check("wh_unlocked", c_locked, 1'b0);

    // 4. Credit exhaustion, single credit return, simultaneous transfer and return.
    apply_reset();
    c_req = 5'b00001; c_head = 5'b00001; c_tail = 5'b00001;
    next_cycle(); #1;
    check("cr_after1", c_credits, 3'd3);
    next_cycle(); #1;
    check("cr_after2", c_credits, 3'd2);
    next_cycle(); #1;
    check("cr_after3", c_credits, 3'd1);
    next_cycle(); #1;
    check("cr_after4", c_credits, 3'd0);
    check("cr_empty_gnt", c_gnt, 5'b00000);
    c_credit_in = 1'b1;
    next_cycle();
    c_credit_in = 1'b0;
    #1;
    check("cr_one_credit", c_credits, 3'd1);
    check("cr_one_gnt", c_gnt, 5'b00001);
    next_cycle(); #1;
    check("cr_one_only_gnt", c_gnt, 5'b00000);
    check("cr_one_only_credits", c_credits, 3'd0);
    c_req = '0; c_credit_in = 1'b1;
    next_cycle();
    next_cycle();
    c_req = 5'b00001;
    #1;
    check("cr_both_pre", c_credits, 3'd2);
    check("cr_both_gnt", c_gnt, 5'b00001);
    next_cycle();
    c_req = '0; c_credit_in = 1'b0;
    #1;
    check("cr_both_post", c_credits, 3'd2);
    check("cr_no_err", c_err, 1'b0);

    // 5. Credit overflow at full count sets a sticky error.
    apply_reset();
    c_credit_in = 1'b1;
    #1;
    check("ovf_pre_err", c_err, 1'b0);
    next_cycle();
    c_credit_in = 1'b0;
    c_req = 5'b00001; c_head = 5'b00001; c_tail = 5'b00001;
    #1;
    check("ovf_credits", c_credits, 3'd4);
    check("ovf_err", c_err, 1'b1);
    next_cycle();
    next_cycle();
    c_req = '0;
    #1;
    check("ovf_traffic_credits", c_credits, 3'd2);
    check("ovf_sticky_err", c_err, 1'b1);

    // 6. Ack/nack mode: stall mid-packet, disabled inputs, reset mid-packet.
    apply_reset();
    a_credit_in = 1'b1;
    a_req = 5'b00010; a_head = 5'b00010; a_tail = 5'b00000;
    #1;
    check("an_head_gnt", a_gnt, 5'b00010);
    next_cycle();
    a_head = 5'b00000; a_stop_in = 1'b1;
    #1;
    check("an_stop_gnt", a_gnt, 5'b00000);
    check("an_stop_locked", a_locked, 1'b1);
    check("an_stop_owner", a_owner, 3'd1);
    check("an_credits", a_credits, 3'd4);
    next_cycle();
    a_stop_in = 1'b0;
    #1;
    check("an_resume_gnt", a_gnt, 5'b00010);
    next_cycle();
    a_req = 5'b00101; a_head = 5'b00101; a_tail = 5'b00101;
    #1;
    check("an_bubble_gnt", a_gnt, 5'b00000);
    check("an_bubble_locked", a_locked, 1'b1);
    rst = 1'b0;
    #1;
    check("an_rst_locked", a_locked, 1'b0);
    check("an_rst_gnt", a_gnt, 5'b00000);
    check("an_rst_owner", a_owner, 3'd0);
    next_cycle();
    rst = 1'b1;
    #1;
    check("an_disabled_gnt0", a_gnt, 5'b00000);
    next_cycle(); #1;
    check("an_disabled_gnt1", a_gnt, 5'b00000);
    a_req = 5'b11010; a_head = 5'b11111; a_tail = 5'b11111;
    #1;
    check("an_rrptr_reset_gnt", a_gnt, 5'b00010);
    check("an_err", a_err, 1'b0);
    check("an_credits_hold", a_credits, 3'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
